// File: rtl/countdown_ctrl.sv
// Single-button sequencing controller for the BCD countdown datapath:
// start / pause / resume / hold-to-clear, then a timed multi-burst alarm.
module countdown_ctrl #(
  parameter int BEEP_ON    = 100,
  parameter int BEEP_OFF   = 100,
  parameter int BEEP_COUNT = 3,
  parameter int HOLD_CLR   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       timebase,
  input  logic       button,
  input  logic       counter_z,
  output logic       counter_clr,
  output logic       counter_en,
  output logic       beep,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_CLR      = 3'd0,
    S_IDLE     = 3'd1,
    S_RUN      = 3'd2,
    S_PAUSE    = 3'd3,
    S_BEEP_ON  = 3'd4,
    S_BEEP_OFF = 3'd5
  } state_t;

  localparam int DUR_MAX = ((BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF) - 1;
  localparam int DUR_W   = (DUR_MAX < 1) ? 1 : $clog2(DUR_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_CLR + 1);
  localparam int BURST_W = $clog2(BEEP_COUNT + 1);

  localparam logic [DUR_W-1:0]   ON_LD     = DUR_W'(BEEP_ON - 1);
  localparam logic [DUR_W-1:0]   OFF_LD    = DUR_W'(BEEP_OFF - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(HOLD_CLR);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BEEP_COUNT);

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               armed_q, armed_d;
  logic               button_prev_q, button_prev_d;
  logic               press, release_ev;

  // button_prev resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLR;
      hold_q        <= '0;
      dur_q         <= '0;
      burst_q       <= '0;
      armed_q       <= 1'b0;
      button_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      dur_q         <= dur_d;
      burst_q       <= burst_d;
      armed_q       <= armed_d;
      button_prev_q <= button_prev_d;
    end
  end

  always_comb begin
    button_prev_d = button;
    press         = button & ~button_prev_q;
    release_ev    = ~button & button_prev_q;
    state_d       = state_q;
    hold_d        = hold_q;
    dur_d         = dur_q;
    burst_d       = burst_q;
    armed_d       = armed_q;

    case (state_q)
      S_CLR: begin
        state_d = S_IDLE;
        hold_d  = '0;
        dur_d   = '0;
        burst_d = '0;
        armed_d = 1'b0;
      end
      S_IDLE: begin
        if (press) state_d = S_RUN;
      end
      S_RUN: begin
        if (counter_z) begin
          state_d = S_BEEP_ON;
          dur_d   = ON_LD;
          burst_d = '0;
        end else if (press) begin
          state_d = S_PAUSE;
          hold_d  = '0;
          armed_d = 1'b0;
        end
      end
      S_PAUSE: begin
        // Hold timer saturates at the limit; reaching it clears without release.
        if (!button) hold_d = '0;
        else if (timebase && (hold_q != HOLD_LIM)) hold_d = hold_q + HOLD_W'(1);
        if (hold_d == HOLD_LIM) begin
          state_d = S_CLR;
        end else if (release_ev) begin
          if (armed_q) state_d = S_RUN;
          else         armed_d = 1'b1;
        end
      end
      S_BEEP_ON: begin
        if (press) begin
          state_d = S_CLR;
        end else if (timebase) begin
          if (dur_q == '0) begin
            state_d = S_BEEP_OFF;
            dur_d   = OFF_LD;
            burst_d = burst_q + BURST_W'(1);
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      S_BEEP_OFF: begin
        if (press) begin
          state_d = S_CLR;
        end else if (timebase) begin
          if (dur_q == '0) begin
            if (burst_q == BURST_LIM) begin
              state_d = S_CLR;
            end else begin
              state_d = S_BEEP_ON;
              dur_d   = ON_LD;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  always_comb begin
    counter_clr = (state_q == S_CLR);
    counter_en  = (state_q == S_RUN);
    beep        = (state_q == S_BEEP_ON);
    fsm_state   = state_q;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencing controller for the shared BCD countdown-counter datapath (clear / enable / zero-flag) used by the timer game.
- Single button: start, pause, resume and hold-to-clear.
- On reaching zero, runs a timed multi-burst beep pattern, then clears the counter and returns to idle.
- All timing is in timebase ticks (1 ms nominal). Sits between the debounced button and the counter/display datapath.

Parameters:
- BEEP_ON, 100, beep burst on-time in ticks (>=1)
- BEEP_OFF, 100, gap between bursts in ticks (>=1)
- BEEP_COUNT, 3, number of bursts per alarm (>=1)
- HOLD_CLR, 2000, button hold time in ticks that clears the counter while paused (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low (0 = reset)
- timebase  in  1  one-cycle tick, 1 ms expected
- button  in  1  debounced, synchronised user button, high = pressed
- counter_z  in  1  datapath flag, counter value == 0
- counter_clr  out  1  one-cycle pulse, reloads the counter preset
- counter_en  out  1  counter decrements on timebase while high
- beep  out  1  buzzer drive
- fsm_state  out  3  current state encoding, for debug/display

Behaviour:
- States and encodings: S_CLR=0, S_IDLE=1, S_RUN=2, S_PAUSE=3, S_BEEP_ON=4, S_BEEP_OFF=5. Codes 6 and 7 go to S_CLR on the next clock.
- Moore outputs, decoded from the state register only:
  - counter_clr=1 only in S_CLR
  - counter_en=1 only in S_RUN
  - beep=1 only in S_BEEP_ON
- Reset (asynchronous, while reset=0):
  - state=S_CLR, so counter_clr=1, counter_en=0, beep=0, fsm_state=0.
  - All timers, burst counter and armed flag = 0; button_prev = 1.
  - button_prev=1 means a button held through reset release does not count as a press.
- Edge detection: button_prev registered every cycle. press = button & ~button_prev; release = ~button & button_prev.
- S_CLR: lasts exactly 1 cycle, then S_IDLE.
- S_IDLE: press -> S_RUN.
- S_RUN:
  - counter_z=1 -> S_BEEP_ON; this has priority over a press in the same cycle.
  - Else press -> S_PAUSE.
  - RUN with counter_z already 1 (zero preset) reaches S_BEEP_ON on the next clock.
- S_PAUSE:
  - On entry: hold timer = 0, armed = 0.
  - hold timer increments on each timebase while button=1; cleared whenever button=0.
  - hold timer reaches HOLD_CLR -> S_CLR immediately; no release needed.
  - release with armed=0 sets armed=1 (the pausing press released) and stays in S_PAUSE.
  - release with armed=1 and hold < HOLD_CLR -> S_RUN (resume).
  - counter_z is ignored in this state.
- Alarm timing:
  - Duration timer loaded with N-1 on entry to S_BEEP_ON (N=BEEP_ON) and S_BEEP_OFF (N=BEEP_OFF).
  - Decrements on timebase; state exits on the cycle where timer==0 and timebase=1.
  - State therefore lasts exactly N ticks.
- Burst sequencing:
  - Burst counter is cleared on entry from S_RUN and incremented on each S_BEEP_ON -> S_BEEP_OFF transition.
  - S_BEEP_OFF expiry: burst count == BEEP_COUNT -> S_CLR, else -> S_BEEP_ON.
- Acknowledge: a press in S_BEEP_ON or S_BEEP_OFF -> S_CLR immediately. It takes priority over timer expiry in the same cycle.
- Widths: timers and burst counter are sized with wordlength() of their maximum value. No wrap is possible: hold timer saturates at HOLD_CLR.
- Reset mid-operation: immediate return to S_CLR on reset assertion; first cycle after release is S_CLR (counter_clr pulse), then S_IDLE.

Test Plan:
- Reset release, button=0 -> counter_clr=1 for exactly 1 cycle, then fsm_state=1; counter_en=0, beep=0.
- Press in IDLE; counter_z driven 1 after 5 ticks, same cycle as a second press -> counter_en=1 for 5 ticks, then S_BEEP_ON; the press is ignored.
- BEEP_ON=3, BEEP_OFF=2, BEEP_COUNT=2, no button -> beep high 3 ticks, low 2, high 3, low 2, then a counter_clr pulse and fsm_state=1.
- In RUN, press and release, then press and release again (hold < HOLD_CLR) -> state 3 after the first press; stays 3 after the first release; returns to 2 on the second release.
- HOLD_CLR=10: press in RUN and hold 10 ticks -> state 3, then S_CLR on the 10th tick, counter_clr pulse, then IDLE; later release causes no transition.
- Press during the first S_BEEP_OFF -> S_CLR on the next clock, beep stays 0. Assert reset mid-S_BEEP_ON -> beep=0 asynchronously, state 0.
